// File: rtl/abz_pkg.sv
// rtl/abz_pkg.sv - shared types and constants for the ABZ segment scheduler
package abz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } abz_state_t;

    typedef struct packed {
        logic [15:0] abm;
        logic [15:0] div;
        logic [15:0] cycles;
    } seg_t;

    localparam int ABZ_Z_LENGTH = 30;
    // Z pulse width plus margin for the generator's phase reset.
    localparam int ABZ_GAP_CYC  = ABZ_Z_LENGTH + 2;

endpackage

// File: rtl/abz_seg_fifo.sv
// rtl/abz_seg_fifo.sv - synchronous segment FIFO with push/pop/flush and fill level
module abz_seg_fifo
    import abz_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic          clk_in,
    input  logic          sys_rst,
    input  logic          push,
    input  seg_t          push_data,
    input  logic          pop,
    output seg_t          pop_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    seg_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/abz_seq_ctrl.sv
// rtl/abz_seq_ctrl.sv - buffers motion segments and plays them into the ABZ generator
module abz_seq_ctrl
    import abz_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYC    = ABZ_GAP_CYC,
    parameter int MIN_DIV    = 4
) (
    input  logic                         clk_in,
    input  logic                         sys_rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [15:0]                  cmd_abm,
    input  logic [15:0]                  cmd_div,
    input  logic [15:0]                  cmd_cycles,
    input  logic                         start,
    input  logic                         stop,
    output logic [15:0]                  abm,
    output logic [15:0]                  pulse_div,
    output logic                         pulse_en,
    output logic                         busy,
    output logic                         seg_done,
    output logic                         cmd_err,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

    abz_state_t  state_q;
    abz_state_t  state_d;
    logic [15:0] abm_q;
    logic [15:0] div_q;
    logic [15:0] remain_q;
    logic [15:0] gap_cnt_q;
    logic [15:0] per_cnt_q;
    logic        seg_done_q;
    logic        seg_done_d;
    logic        cmd_err_q;
    logic        pop;
    logic        run_wrap;
    logic        cmd_accept;
    logic        cmd_legal;
    logic        fifo_full;
    logic        fifo_empty;
    seg_t        head;
    seg_t        cmd_seg;

    assign cmd_ready  = !fifo_full && !stop && !sys_rst;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign cmd_legal  = (cmd_div >= MIN_DIV_W);
    assign cmd_seg    = '{abm: cmd_abm, div: cmd_div, cycles: cmd_cycles};
    assign run_wrap   = (per_cnt_q == div_q - 16'd1);

    abz_seg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .sys_rst   (sys_rst),
        .push      (cmd_accept && cmd_legal),
        .push_data (cmd_seg),
        .pop       (pop),
        .pop_data  (head),
        .flush     (stop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seg_done_d = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A remaining count of zero here can only mean a continuous segment.
                if (run_wrap) begin
                    if (remain_q == 16'd1) begin
                        seg_done_d = 1'b1;
                        state_d    = fifo_empty ? IDLE : LOAD;
                    end else if (remain_q == 16'd0 && !fifo_empty) begin
                        seg_done_d = 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d    = IDLE;
            seg_done_d = 1'b0;
            pop        = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            abm_q      <= '0;
            div_q      <= '0;
            remain_q   <= '0;
            gap_cnt_q  <= '0;
            per_cnt_q  <= '0;
            seg_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            seg_done_q <= seg_done_d;
            cmd_err_q  <= cmd_accept && !cmd_legal;
            if (pop) begin
                abm_q    <= head.abm;
                div_q    <= head.div;
                remain_q <= head.cycles;
            end else if (state_q == RUN && run_wrap && remain_q != 16'd0) begin
                remain_q <= remain_q - 16'd1;
            end
            gap_cnt_q <= (state_q == SETTLE) ? gap_cnt_q + 16'd1 : '0;
            per_cnt_q <= (state_q == RUN && !run_wrap) ? per_cnt_q + 16'd1 : '0;
        end
    end

    assign abm       = abm_q;
    assign pulse_div = div_q;
    assign pulse_en  = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign seg_done  = seg_done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_abz_seq_ctrl.sv
// tb/tb_abz_seq_ctrl.sv - directed self-checking bench for abz_seq_ctrl
module tb_abz_seq_ctrl;

    logic        clk_in = 1'b0;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_abm;
    logic [15:0] cmd_div;
    logic [15:0] cmd_cycles;
    logic        start;
    logic        stop;
    logic [15:0] abm;
    logic [15:0] pulse_div;
    logic        pulse_en;
    logic        busy;
    logic        seg_done;
    logic        cmd_err;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    abz_seq_ctrl dut (
        .clk_in     (clk_in),
        .sys_rst    (sys_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_abm    (cmd_abm),
        .cmd_div    (cmd_div),
        .cmd_cycles (cmd_cycles),
        .start      (start),
        .stop       (stop),
        .abm        (abm),
        .pulse_div  (pulse_div),
        .pulse_en   (pulse_en),
        .busy       (busy),
        .seg_done   (seg_done),
        .cmd_err    (cmd_err),
        .fifo_level (fifo_level)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d, input logic [15:0] c);
        cmd_valid  = 1'b1;
        cmd_abm    = a;
        cmd_div    = d;
        cmd_cycles = c;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!pulse_en && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (pulse_en && n < 1000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int lo;
        int hi;
        int r;
        int sd;

        sys_rst    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_abm    = 16'h0;
        cmd_div    = 16'h0;
        cmd_cycles = 16'h0;
        start      = 1'b0;
        stop       = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_abm", abm, 0);
        chk("rst_pulse_div", pulse_div, 0);
        chk("rst_pulse_en", pulse_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seg_done", seg_done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_fifo_level", fifo_level, 0);
        sys_rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // single segment
        push(16'h0010, 16'd8, 16'd3);
        chk("s1_level", fifo_level, 1);
        pulse_start();
        chk("s1_busy_load", busy, 1);
        chk("s1_abm_hold", abm, 0);
        tick();
        chk("s1_abm", abm, 16'h0010);
        chk("s1_div", pulse_div, 8);
        count_low(lo);
        chk("s1_gap", lo, 32);
        count_high(hi);
        chk("s1_run_len", hi, 24);
        chk("s1_seg_done", seg_done, 1);
        chk("s1_busy_end", busy, 0);
        tick();
        chk("s1_seg_done_clr", seg_done, 0);

        // back-to-back segments
        push(16'h0001, 16'd8, 16'd2);
        push(16'h0002, 16'd12, 16'd1);
        chk("b2b_level2", fifo_level, 2);
        pulse_start();
        tick();
        chk("b2b_level1", fifo_level, 1);
        chk("b2b_abm1", abm, 1);
        count_low(lo);
        chk("b2b_gap1", lo, 32);
        count_high(hi);
        chk("b2b_run1", hi, 16);
        chk("b2b_done1", seg_done, 1);
        chk("b2b_abm_before", abm, 1);
        tick();
        chk("b2b_abm2", abm, 2);
        chk("b2b_div2", pulse_div, 12);
        chk("b2b_level0", fifo_level, 0);
        count_low(lo);
        chk("b2b_gap2", lo, 32);
        count_high(hi);
        chk("b2b_run2", hi, 12);
        chk("b2b_done2", seg_done, 1);
        chk("b2b_idle", busy, 0);

        // continuous segment switched out on a period wrap
        push(16'h0005, 16'd4, 16'd0);
        pulse_start();
        tick();
        chk("cont_abm5", abm, 5);
        count_low(lo);
        chk("cont_gap", lo, 32);
        r = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            r++;
        end
        chk("cont_still_running", pulse_en, 1);
        push(16'h0006, 16'd4, 16'd1);
        r++;
        while (pulse_en && r < 400) begin
            tick();
            r++;
        end
        chk("cont_switch_cycle", r, 104);
        chk("cont_seg_done", seg_done, 1);
        tick();
        chk("cont_abm6", abm, 6);
        count_low(lo);
        count_high(hi);
        chk("cont_run6", hi, 4);
        chk("cont_idle", busy, 0);

        // FIFO full and illegal divider
        for (int i = 0; i < 4; i++) begin
            push(16'h0040 + 16'(i), 16'd4, 16'd1);
        end
        chk("full_level", fifo_level, 4);
        chk("full_ready", cmd_ready, 0);
        push(16'h0099, 16'd4, 16'd1);
        chk("full_level_kept", fifo_level, 4);
        chk("full_no_err", cmd_err, 0);
        pulse_start();
        tick();
        chk("full_after_pop", fifo_level, 3);
        chk("full_head_abm", abm, 16'h0040);
        chk("full_ready_again", cmd_ready, 1);
        push(16'h0007, 16'd2, 16'd1);
        chk("rej_cmd_err", cmd_err, 1);
        chk("rej_level", fifo_level, 3);
        tick();
        chk("rej_cmd_err_clr", cmd_err, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("full_stop_level", fifo_level, 0);
        chk("full_stop_busy", busy, 0);

        // stop during RUN
        push(16'h0021, 16'd8, 16'd4);
        push(16'h0022, 16'd8, 16'd1);
        pulse_start();
        tick();
        count_low(lo);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("stop_pre_en", pulse_en, 1);
        stop       = 1'b1;
        cmd_valid  = 1'b1;
        cmd_abm    = 16'h0055;
        cmd_div    = 16'd8;
        cmd_cycles = 16'd1;
        #1;
        chk("stop_cmd_ready", cmd_ready, 0);
        tick();
        stop      = 1'b0;
        cmd_valid = 1'b0;
        chk("stop_pulse_en", pulse_en, 0);
        chk("stop_level", fifo_level, 0);
        chk("stop_busy", busy, 0);
        sd = 0;
        for (int i = 0; i < 10; i++) begin
            if (seg_done) sd++;
            tick();
        end
        chk("stop_no_seg_done", sd, 0);
        pulse_start();
        chk("stop_start_ignored", busy, 0);
        tick();
        chk("stop_start_ignored2", busy, 0);

        // reset during SETTLE
        push(16'h0033, 16'd6, 16'd2);
        push(16'h0034, 16'd6, 16'd1);
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("rs_settle_busy", busy, 1);
        chk("rs_settle_en", pulse_en, 0);
        chk("rs_settle_abm", abm, 16'h0033);
        sys_rst = 1'b1;
        tick();
        chk("rs_abm", abm, 0);
        chk("rs_div", pulse_div, 0);
        chk("rs_en", pulse_en, 0);
        chk("rs_busy", busy, 0);
        chk("rs_level", fifo_level, 0);
        chk("rs_cmd_ready", cmd_ready, 0);
        sys_rst = 1'b0;
        tick();
        chk("rs_ready_after", cmd_ready, 1);
        pulse_start();
        chk("rs_start_empty", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
